// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serial transmitter.
// Optional feature macro: PISO_PARITY_EN (adds one even-parity bit period per frame).
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 1;

  // Number of bit periods in one frame for a given data width.
  function automatic int frame_bits(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: emits a one-cycle tick every DIV clocks while not cleared.
// The tick lands in the last cycle of each bit period.
module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter: held at zero while cleared, wraps LAST -> 0 on each tick.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in/serial-out transmitter, MSB first, one bit per DIV clocks, with a
// receiver sample strobe per bit and a one-cycle done pulse after the frame.
// Optional feature macro: PISO_PARITY_EN (extra trailing even-parity bit).
module piso_shift_transmitter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int            N        = frame_bits(WIDTH);
  localparam int            BW       = $clog2(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  sreg;
  logic [N-1:0]  frame_word;
  logic [BW-1:0] bit_cnt;
  logic          tick;
  logic          accept;

`ifdef PISO_PARITY_EN
  // Parity bit rides in the LSB so it leaves after the last data bit.
  assign frame_word = {load_data, ^load_data};
`else
  assign frame_word = load_data;
`endif

  // Words are only taken in IDLE; anything offered mid-frame is dropped.
  assign accept = load_valid && (state == IDLE);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state != SHIFT),
    .tick  (tick)
  );

  // State register plus shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sreg    <= frame_word;
        bit_cnt <= '0;
      end else if (tick) begin
        sreg    <= {sreg[N-2:0], 1'b0};
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  // Next-state and Moore-style outputs; serial line is quiet outside SHIFT.
  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    serial_out = 1'b0;
    bit_strobe = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        serial_out = sreg[N-1];
        bit_strobe = tick;
        if (tick && (bit_cnt == LAST_BIT)) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Bench for piso_shift_transmitter: two instances (DIV=1 and DIV=4) on one clock.
// Per-cycle line checks plus a loopback SIPO scoreboard. Honors PISO_PARITY_EN.
module tb_piso_shift_transmitter;

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lv_w = '0;
  logic [7:0] ld_w [2];
  logic [1:0] lr_w, so_w, bs_w, busy_w, done_w;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  piso_shift_transmitter #(.WIDTH(8), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .load_valid(lv_w[0]), .load_ready(lr_w[0]),
    .load_data(ld_w[0]), .serial_out(so_w[0]), .bit_strobe(bs_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  piso_shift_transmitter #(.WIDTH(8), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .load_valid(lv_w[1]), .load_ready(lr_w[1]),
    .load_data(ld_w[1]), .serial_out(so_w[1]), .bit_strobe(bs_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    check({tag, "_ready"}, 32'(lr_w[idx]), 32'd1);
    check({tag, "_so"},    32'(so_w[idx]), 32'd0);
    check({tag, "_strb"},  32'(bs_w[idx]), 32'd0);
    check({tag, "_busy"},  32'(busy_w[idx]), 32'd0);
    check({tag, "_done"},  32'(done_w[idx]), 32'd0);
  endtask

  // Loopback SIPO: shift on strobe, compare against the scoreboard on done.
  logic [8:0] sh [2];
  int         nb [2];
  initial begin
    logic [7:0] exp_w;
    logic [7:0] got_w;
    sh[0] = '0; sh[1] = '0; nb[0] = 0; nb[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin sh[i] = '0; nb[i] = 0; end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (bs_w[i]) begin
            sh[i] = {sh[i][7:0], so_w[i]};
            nb[i]++;
          end
          if (done_w[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              check("done_with_empty_queue", 32'd1, 32'd0);
            end else begin
              exp_w = (i == 0) ? q0.pop_front() : q1.pop_front();
`ifdef PISO_PARITY_EN
              got_w = sh[i][8:1];
              check("parity_bit", 32'(sh[i][0]), 32'(^exp_w));
`else
              got_w = sh[i][7:0];
`endif
              check("loopback_word", 32'(got_w), 32'(exp_w));
              check("strobe_count", 32'(nb[i]), 32'(NB));
            end
            sh[i] = '0;
            nb[i] = 0;
          end
        end
      end
    end
  end

  // Send one word on instance idx and check every cycle of the frame.
  // inject_at: SHIFT cycle in which an ignored 8'hFF is offered (0 = none).
  // abort_at:  SHIFT cycle after which rst is asserted (0 = none).
  task automatic xfer(input int idx, input int div, input logic [7:0] w,
                      input int inject_at, input int abort_at);
    logic [8:0] fr;
    int guard;
    int total;
`ifdef PISO_PARITY_EN
    fr = {w, ^w};
`else
    fr = {1'b0, w};
`endif
    total = NB * div;
    @(negedge clk);
    lv_w[idx] = 1'b1;
    ld_w[idx] = w;
    guard = 0;
    while (!lr_w[idx] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!lr_w[idx]) begin
      check("accept_timeout", 32'd0, 32'd1);
      lv_w[idx] = 1'b0;
      return;
    end
    if (idx == 0) q0.push_back(w); else q1.push_back(w);
    @(posedge clk);
    @(negedge clk);
    lv_w[idx] = 1'b0;
    for (int k = 1; k <= total; k++) begin
      check("serial_bit", 32'(so_w[idx]), 32'(fr[NB - 1 - (k - 1) / div]));
      check("bit_strobe", 32'(bs_w[idx]), 32'((k % div) == 0));
      check("ready_low",  32'(lr_w[idx]), 32'd0);
      check("busy_high",  32'(busy_w[idx]), 32'd1);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_idle(idx, "abort");
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < total + 2; j++) begin
          @(negedge clk);
          check("no_done_after_abort", 32'(done_w[idx]), 32'd0);
        end
        return;
      end
      lv_w[idx] = (k == inject_at);
      if (k == inject_at) ld_w[idx] = 8'hFF;
      @(negedge clk);
    end
    lv_w[idx] = 1'b0;
    check("done_pulse", 32'(done_w[idx]), 32'd1);
    check("done_so",    32'(so_w[idx]), 32'd0);
    check("done_busy",  32'(busy_w[idx]), 32'd1);
    check("done_ready", 32'(lr_w[idx]), 32'd0);
    @(negedge clk);
    check("ready_again", 32'(lr_w[idx]), 32'd1);
    check("done_cleared", 32'(done_w[idx]), 32'd0);
    check("busy_cleared", 32'(busy_w[idx]), 32'd0);
  endtask

  initial begin
    ld_w[0] = '0;
    ld_w[1] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst = 1'b0;

    xfer(0, 1, 8'hA5, 0, 0);
    xfer(1, 4, 8'h81, 0, 0);
    xfer(1, 4, 8'h00, 3, 0);
    xfer(1, 4, 8'hC3, 0, 5);
    xfer(1, 4, 8'h3C, 0, 0);
    xfer(1, 4, 8'h07, 0, 0);
    xfer(1, 4, 8'h03, 0, 0);
    xfer(0, 1, 8'h5A, 0, 0);
    xfer(0, 1, 8'h00, 0, 0);
    xfer(0, 1, 8'hFF, 0, 0);

    repeat (4) @(negedge clk);
    check("queue0_drained", 32'(q0.size()), 32'd0);
    check("queue1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
